nonce_controller: RTL and testbench

Mining-loop controller that feeds the hash core of the optimised-throughput system. It latches the 12-byte header (data_in) and 8-bit target, appends a 32-bit nonce to form the 16-byte block, and starts the hash core. It compares each returned hash against the target and sweeps nonces until a hash passes, then reports finished and nonce_out to the system top. The hash core sits downstream of block_out and hash_start; the system probe drives data_in and target.

---
 rtl/mining_pkg.sv | 32 +++
 rtl/nonce_controller_if.sv | 21 ++
 rtl/nonce_controller_target_compare.sv | 15 +
 rtl/nonce_controller.sv | 140 ++++++++++++++
 tb/tb_nonce_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mining_pkg.sv
// Shared definitions for the mining loop.
//   - Geometry of header, block, nonce and hash words.
//   - Controller FSM state encoding (3-bit).
//   - hash_meets_target(): the pass rule. The system checker reuses it.
package mining_pkg;

    localparam int BYTE      = 8;
    localparam int HDR_BYTES = 12;
    localparam int BLK_BYTES = 16;
    localparam int NONCE_W   = 32;
    localparam int HASH_W    = 24;
    localparam int HDR_W     = BYTE * HDR_BYTES;
    localparam int BLK_W     = BYTE * BLK_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_HASH = 3'd2,
        ST_CHECK     = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } state_e;

    // Byte 0 ([23:16]) and byte 1 ([15:8]) must both be strictly below the
    // target (unsigned). Byte 2 plays no part. A target of 0 can never pass.
    function automatic logic hash_meets_target(input logic [HASH_W-1:0] hash,
                                               input logic [BYTE-1:0]   target);
        return (hash[HASH_W-1 -: BYTE] < target) &&
               (hash[HASH_W-BYTE-1 -: BYTE] < target);
    endfunction

endpackage

// File: rtl/nonce_controller_if.sv
// Handshake bus between the nonce controller and the hash core.
//   block_out  : 16-byte block {header, nonce}; the nonce is in bits [31:0]
//   hash_start : one-cycle pulse; block_out is valid during it
//   hash_done  : one-cycle pulse from the hash core; hash_value is valid
//   hash_value : 24-bit hash result
// The master modport is the controller side. The slave modport is the
// hash-core side.
interface nonce_controller_if;
    import mining_pkg::*;

    logic [BLK_W-1:0]  block_out;
    logic              hash_start;
    logic              hash_done;
    logic [HASH_W-1:0] hash_value;

    modport master (output block_out, hash_start,
                    input  hash_done, hash_value);

    modport slave  (input  block_out, hash_start,
                    output hash_done, hash_value);
endinterface

// File: rtl/nonce_controller_target_compare.sv
// target_compare: combinational pass/fail of a hash against the target.
//   hash_i   : 24-bit hash result
//   target_i : 8-bit difficulty threshold
//   pass_o   : 1 when both leading hash bytes are strictly below target_i
module target_compare
    import mining_pkg::*;
(
    input  logic [HASH_W-1:0] hash_i,
    input  logic [BYTE-1:0]   target_i,
    output logic              pass_o
);

    assign pass_o = hash_meets_target(hash_i, target_i);

endmodule

// File: rtl/nonce_controller.sv
// nonce_controller: mining-loop controller in front of the hash core.
// It latches the header and target once per run. It then sweeps nonces from
// 0 and, for each one, hands the 16-byte block {header, nonce} to the hash
// core. The sweep stops at the first passing hash (finished, nonce_out) or
// after NONCE_MAX fails (exhausted). Both end states are held until reset.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low
//   data_in    : 12-byte header, sampled once per run
//   target     : 8-bit threshold, sampled together with data_in
//   hc         : hash-core bus (block_out, hash_start, hash_done, hash_value)
//   finished   : a passing nonce was found
//   exhausted  : every nonce up to NONCE_MAX failed
//   nonce_out  : winning nonce, valid while finished=1
module nonce_controller
    import mining_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_MAX = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HDR_W-1:0]    data_in,
    input  logic [BYTE-1:0]     target,
    nonce_controller_if.master  hc,
    output logic                finished,
    output logic                exhausted,
    output logic [NONCE_W-1:0]  nonce_out
);

    state_e             state_q,     state_d;
    logic [NONCE_W-1:0] nonce_q,     nonce_d;
    logic [HDR_W-1:0]   header_q,    header_d;
    logic [BYTE-1:0]    target_q,    target_d;
    logic [BLK_W-1:0]   block_q,     block_d;
    logic [HASH_W-1:0]  hash_q,      hash_d;
    logic               finished_q,  finished_d;
    logic               exhausted_q, exhausted_d;
    logic [NONCE_W-1:0] nonce_out_q, nonce_out_d;
    logic               hash_start;
    logic               hash_pass;

    target_compare u_target_compare (
        .hash_i   (hash_q),
        .target_i (target_q),
        .pass_o   (hash_pass)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            nonce_q     <= '0;
            header_q    <= '0;
            target_q    <= '0;
            block_q     <= '0;
            hash_q      <= '0;
            finished_q  <= 1'b0;
            exhausted_q <= 1'b0;
            nonce_out_q <= '0;
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            header_q    <= header_d;
            target_q    <= target_d;
            block_q     <= block_d;
            hash_q      <= hash_d;
            finished_q  <= finished_d;
            exhausted_q <= exhausted_d;
            nonce_out_q <= nonce_out_d;
        end
    end

    // The block is registered on the edge that enters LOAD. That makes it
    // valid for the whole hash_start cycle, and it stays stable through
    // WAIT_HASH.
    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_q;
        header_d    = header_q;
        target_d    = target_q;
        block_d     = block_q;
        hash_d      = hash_q;
        finished_d  = finished_q;
        exhausted_d = exhausted_q;
        nonce_out_d = nonce_out_q;
        hash_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                header_d = data_in;
                target_d = target;
                nonce_d  = '0;
                block_d  = {data_in, {NONCE_W{1'b0}}};
                state_d  = ST_LOAD;
            end

            ST_LOAD: begin
                hash_start = 1'b1;
                state_d    = ST_WAIT_HASH;
            end

            ST_WAIT_HASH: begin
                if (hc.hash_done) begin
                    hash_d  = hc.hash_value;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (hash_pass) begin
                    nonce_out_d = nonce_q;
                    finished_d  = 1'b1;
                    state_d     = ST_FOUND;
                end else if (nonce_q == NONCE_MAX) begin
                    // Stop here rather than wrapping back to nonce 0.
                    exhausted_d = 1'b1;
                    state_d     = ST_EXHAUSTED;
                end else begin
                    nonce_d = nonce_q + 1'b1;
                    block_d = {header_q, nonce_q + 1'b1};
                    state_d = ST_LOAD;
                end
            end

            ST_FOUND,
            ST_EXHAUSTED: begin
                state_d = state_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hc.block_out  = block_q;
    assign hc.hash_start = hash_start;
    assign finished      = finished_q;
    assign exhausted     = exhausted_q;
    assign nonce_out     = nonce_out_q;

endmodule

// File: tb/tb_nonce_controller.sv
module tb_nonce_controller;

    localparam logic [31:0] NMAX = 32'd7;
    localparam logic [95:0] HDR_A = 96'h397d9f2f40ca9e6c6b1f3324;
    localparam logic [95:0] HDR_B = 96'h3c87edfd24331f6b6c9eca40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [95:0] data_in = '0;
    logic [7:0]  target = '0;
    logic        finished;
    logic        exhausted;
    logic [31:0] nonce_out;

    nonce_controller_if hc_bus ();

    nonce_controller #(.NONCE_MAX(NMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .target    (target),
        .hc        (hc_bus),
        .finished  (finished),
        .exhausted (exhausted),
        .nonce_out (nonce_out)
    );

    // Standalone comparator instance
    logic [23:0] tc_hash = '0;
    logic [7:0]  tc_tgt = '0;
    logic        tc_pass;

    target_compare u_tc (
        .hash_i   (tc_hash),
        .target_i (tc_tgt),
        .pass_o   (tc_pass)
    );

    always #5 clk = ~clk;

    // Stub hash core: five registered cycles after it samples hash_start.
    // It answers with the table entry for the nonce it was given.
    logic [23:0] hv [0:7];
    logic [5:0]  dly;
    logic [31:0] stub_nonce;
    logic        inj_done = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly        <= '0;
            stub_nonce <= '0;
        end else begin
            dly <= {dly[4:0], hc_bus.hash_start};
            if (hc_bus.hash_start) stub_nonce <= hc_bus.block_out[31:0];
        end
    end

    assign hc_bus.hash_done  = dly[5] | inj_done;
    assign hc_bus.hash_value = hv[stub_nonce[2:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full run from reset. The expected outcome comes from scanning the
    // hash table for the first nonce whose two leading bytes are both below
    // the target.
    task automatic run_sweep(input string tag, input logic [95:0] hdr,
                             input logic [7:0] tgt, input bit swap_inputs);
        int exp_n;
        int exp_starts;
        int hs;
        int last_hs;
        int done_cyc;
        int extra;
        exp_n = -1;
        for (int n = 0; n <= int'(NMAX); n++)
            if (exp_n < 0 && hv[n][23:16] < tgt && hv[n][15:8] < tgt) exp_n = n;
        exp_starts = (exp_n >= 0) ? exp_n + 1 : int'(NMAX) + 1;

        data_in = hdr;
        target  = tgt;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        hs = 0; last_hs = -1; done_cyc = -1;
        for (int c = 0; c < 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (hc_bus.hash_start) begin
                chk({tag, " hdr"}, hc_bus.block_out[127:32], hdr);
                chk({tag, " nonce"}, hc_bus.block_out[31:0], hs);
                hs++;
                last_hs = c;
                if (swap_inputs && hs == 2) begin
                    data_in = ~hdr;
                    target  = ~tgt;
                end
            end
            if (finished || exhausted) done_cyc = c;
        end
        chk({tag, " timeout"}, done_cyc >= 0, 1'b1);
        chk({tag, " starts"}, hs, exp_starts);
        chk({tag, " finished"}, finished, exp_n >= 0);
        chk({tag, " exhausted"}, exhausted, exp_n < 0);
        chk({tag, " nonce_out"}, nonce_out, (exp_n >= 0) ? exp_n : 0);
        chk({tag, " latency"}, done_cyc - last_hs, 8);

        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (hc_bus.hash_start) extra++;
        end
        chk({tag, " quiet"}, extra, 0);
        chk({tag, " held"}, {finished, exhausted}, {exp_n >= 0, exp_n < 0});
    endtask

    initial begin
        logic [23:0] h;
        logic [7:0]  t;
        logic [95:0] rh;
        bit          seen;
        int          hs;
        int          first;
        int          done;

        for (int n = 0; n < 8; n++) hv[n] = 24'hFFFFFF;

        // Reset values
        #1 reset = 1'b0;
        #1;
        chk("rst block_out", hc_bus.block_out, 0);
        chk("rst hash_start", hc_bus.hash_start, 0);
        chk("rst finished", finished, 0);
        chk("rst exhausted", exhausted, 0);
        chk("rst nonce_out", nonce_out, 0);

        // Comparator alone: strict boundaries on each byte independently
        tc_tgt = 8'h96;
        tc_hash = 24'h961000; #1 chk("tc b0 eq", tc_pass, 0);
        tc_hash = 24'h109600; #1 chk("tc b1 eq", tc_pass, 0);
        tc_hash = 24'h959500; #1 chk("tc both lt", tc_pass, 1);
        tc_hash = 24'h9595FF; #1 chk("tc b2 ignored", tc_pass, 1);
        tc_tgt = 8'h00; tc_hash = 24'h000000; #1 chk("tc tgt0", tc_pass, 0);
        for (int i = 0; i < 20; i++) begin
            h = 24'($urandom);
            t = 8'($urandom);
            tc_hash = h; tc_tgt = t;
            #1 chk("tc rand", tc_pass, (h[23:16] < t) && (h[15:8] < t));
        end

        // Single hash passes on nonce 0
        hv[0] = 24'h102030;
        run_sweep("first", HDR_A, 8'd150, 1'b0);

        // Passes on nonce 3
        for (int n = 0; n < 8; n++) hv[n] = 24'hFFFF00;
        hv[3] = 24'h959500;
        run_sweep("n3", HDR_A, 8'd150, 1'b0);

        // Strict boundary on each byte, then a pass
        for (int n = 0; n < 8; n++) hv[n] = 24'hFFFFFF;
        hv[0] = 24'h961000;
        hv[1] = 24'h109600;
        hv[2] = 24'h959500;
        run_sweep("bound", HDR_A, 8'h96, 1'b0);

        // Exhaust at NONCE_MAX
        for (int n = 0; n < 8; n++) hv[n] = 24'hFFFFFF;
        run_sweep("exhaust", HDR_A, 8'd150, 1'b0);

        // target 0 never passes
        for (int n = 0; n < 8; n++) hv[n] = 24'h000000;
        run_sweep("tgt0", HDR_A, 8'd0, 1'b0);

        // Inputs changed mid-sweep are ignored; the next run uses the new header
        for (int n = 0; n < 8; n++) hv[n] = 24'hFFFFFF;
        hv[5] = 24'h010100;
        run_sweep("swap", HDR_A, 8'd150, 1'b1);
        run_sweep("swap new", HDR_B, 8'd150, 1'b0);

        // Asynchronous reset during WAIT_HASH, then a late hash_done
        for (int n = 0; n < 8; n++) hv[n] = 24'h000000;
        data_in = HDR_A; target = 8'd150; reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (hc_bus.hash_start) seen = 1'b1;
        end
        chk("ar start", seen, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar block_out", hc_bus.block_out, 0);
        chk("ar hash_start", hc_bus.hash_start, 0);
        chk("ar finished", finished, 0);
        chk("ar exhausted", exhausted, 0);
        chk("ar nonce_out", nonce_out, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        inj_done = 1'b1;
        hs = 0; first = -1; done = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 1) inj_done = 1'b0;
            if (hc_bus.hash_start) begin
                hs++;
                if (first < 0) first = c;
            end
            if (finished && done < 0) done = c;
        end
        chk("ar first start", first, 0);
        chk("ar starts", hs, 1);
        chk("ar latency", done - first, 8);
        chk("ar nonce_out", nonce_out, 0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            rh = {$urandom, $urandom, $urandom};
            t  = (r == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            for (int n = 0; n < 8; n++) begin
                if ($urandom_range(0, 3) == 0)
                    hv[n] = {8'($urandom_range(0, 60)), 8'($urandom_range(0, 60)), 8'($urandom)};
                else
                    hv[n] = 24'($urandom);
            end
            run_sweep($sformatf("rand%0d", r), rh, t, r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
